// File: rtl/mul_wb_buffer.sv
// Merges M5 multiply results and ALU results onto one register-file write port; ALU wins, and losing multiply results queue in a small FIFO.
// Write outputs are registered (M5-to-wb bypass is 1 cycle); mul_stall holds M5 while the FIFO is full.
module mul_wb_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m5_valid,
  input  logic [DATA_W-1:0] m5_result,
  input  logic              m5_zero,
  input  logic              m5_overflow,
  input  logic [4:0]        m5_dst,
  output logic              mul_stall,
  input  logic              alu_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [4:0]        alu_dst,
  input  logic              flush,
  input  logic [4:0]        query_dst,
  output logic              query_hit,
  output logic              wb_en,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_dst,
  output logic              wb_zero,
  output logic              mul_exc
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [4:0]        dst;
    logic              zero;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              wb_en_q, wb_en_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [4:0]        wb_dst_q, wb_dst_d;
  logic              wb_zero_q, wb_zero_d;
  logic              mul_exc_q, mul_exc_d;

  logic   m5_accept;
  logic   m5_elig;
  logic   push;
  logic   pop;
  entry_t m5_entry;
  entry_t head;

  assign mul_stall = (count_q == (AW+1)'(DEPTH));
  assign m5_accept = m5_valid && !mul_stall && !flush;
  // Overflowed results and writes to r0 are accepted but never reach the port.
  assign m5_elig   = m5_accept && !m5_overflow && (m5_dst != 5'd0);
  assign m5_entry  = '{data: m5_result, dst: m5_dst, zero: m5_zero};
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wb_en_d   = 1'b0;
    wb_data_d = wb_data_q;
    wb_dst_d  = wb_dst_q;
    wb_zero_d = wb_zero_q;
    mul_exc_d = m5_accept && m5_overflow;
    push      = 1'b0;
    pop       = 1'b0;

    if (alu_valid) begin
      wb_en_d   = 1'b1;
      wb_data_d = alu_result;
      wb_dst_d  = alu_dst;
      wb_zero_d = (alu_result == '0);
      push      = m5_elig;
    end else if (count_q != '0) begin
      // A flush cancels the pop; the queued entries are discarded instead.
      if (!flush) begin
        pop       = 1'b1;
        wb_en_d   = 1'b1;
        wb_data_d = head.data;
        wb_dst_d  = head.dst;
        wb_zero_d = head.zero;
      end
      push = m5_elig;
    end else if (m5_elig) begin
      wb_en_d   = 1'b1;
      wb_data_d = m5_result;
      wb_dst_d  = m5_dst;
      wb_zero_d = m5_zero;
    end

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = m5_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_comb begin
    query_hit = 1'b0;
    if (query_dst != 5'd0) begin
      if (m5_elig && (m5_dst == query_dst)) begin
        query_hit = 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (((AW+1)'(i) < count_q) && (mem_q[rd_ptr_q + AW'(i)].dst == query_dst)) begin
          query_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_data_q <= '0;
      wb_dst_q  <= '0;
      wb_zero_q <= 1'b0;
      mul_exc_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wb_en_q   <= wb_en_d;
      wb_data_q <= wb_data_d;
      wb_dst_q  <= wb_dst_d;
      wb_zero_q <= wb_zero_d;
      mul_exc_q <= mul_exc_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_data = wb_data_q;
  assign wb_dst  = wb_dst_q;
  assign wb_zero = wb_zero_q;
  assign mul_exc = mul_exc_q;

endmodule

// File: tb/tb_mul_wb_buffer.sv
// Directed bench for mul_wb_buffer: hand-computed expectations checked with immediate assertions.
module tb_mul_wb_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m5_valid;
  logic [31:0] m5_result;
  logic        m5_zero;
  logic        m5_overflow;
  logic [4:0]  m5_dst;
  logic        mul_stall;
  logic        alu_valid;
  logic [31:0] alu_result;
  logic [4:0]  alu_dst;
  logic        flush;
  logic [4:0]  query_dst;
  logic        query_hit;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst;
  logic        wb_zero;
  logic        mul_exc;

  int n_cmp = 0;
  int n_err = 0;

  mul_wb_buffer #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m5_valid(m5_valid), .m5_result(m5_result), .m5_zero(m5_zero),
    .m5_overflow(m5_overflow), .m5_dst(m5_dst), .mul_stall(mul_stall),
    .alu_valid(alu_valid), .alu_result(alu_result), .alu_dst(alu_dst),
    .flush(flush), .query_dst(query_dst), .query_hit(query_hit),
    .wb_en(wb_en), .wb_data(wb_data), .wb_dst(wb_dst), .wb_zero(wb_zero),
    .mul_exc(mul_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m5_valid    = 1'b0;
    m5_result   = '0;
    m5_zero     = 1'b0;
    m5_overflow = 1'b0;
    m5_dst      = '0;
    alu_valid   = 1'b0;
    alu_result  = '0;
    alu_dst     = '0;
    flush       = 1'b0;
  endtask

  task automatic m5(input logic [31:0] res, input logic [4:0] dst, input logic ovf);
    m5_valid    = 1'b1;
    m5_result   = res;
    m5_zero     = (res == 32'd0);
    m5_overflow = ovf;
    m5_dst      = dst;
  endtask

  task automatic alu(input logic [31:0] res, input logic [4:0] dst);
    alu_valid  = 1'b1;
    alu_result = res;
    alu_dst    = dst;
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] d, input logic [4:0] dst, input logic z);
    chk({tag, "_en"}, wb_en, 1'b1);
    chk({tag, "_data"}, wb_data, d);
    chk({tag, "_dst"}, wb_dst, dst);
    chk({tag, "_zero"}, wb_zero, z);
  endtask

  initial begin
    idle();
    query_dst = '0;
    rst_n = 1'b0;
    #3;
    chk("rst_wb_en", wb_en, 1'b0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_dst", wb_dst, 5'd0);
    chk("rst_wb_zero", wb_zero, 1'b0);
    chk("rst_mul_exc", mul_exc, 1'b0);
    chk("rst_stall", mul_stall, 1'b0);
    chk("rst_qhit", query_hit, 1'b0);
    #4 rst_n = 1'b1;
    tick();

    // Bypass: empty FIFO, no ALU
    m5(32'h6, 5'd5, 1'b0);
    tick();
    idle();
    chk_wb("byp", 32'h6, 5'd5, 1'b0);
    tick();
    chk("byp_idle_en", wb_en, 1'b0);
    chk("byp_hold_data", wb_data, 32'h6);
    chk("byp_hold_dst", wb_dst, 5'd5);

    // Priority and ordering: ALU busy while M5 issues r1..r5
    for (int k = 1; k <= 4; k++) begin
      alu(32'd100 + 32'(k), 5'd20);
      m5(32'd10 * 32'(k), 5'(k), 1'b0);
      #1;
      chk("pri_stall_lo", mul_stall, 1'b0);
      tick();
      chk_wb("pri_alu", 32'd100 + 32'(k), 5'd20, 1'b0);
    end
    alu(32'd105, 5'd20);
    m5(32'd50, 5'd5, 1'b0);
    query_dst = 5'd3;
    #1;
    chk("pri_stall_full", mul_stall, 1'b1);
    chk("pri_qhit_r3", query_hit, 1'b1);
    tick();
    chk_wb("pri_alu5", 32'd105, 5'd20, 1'b0);
    alu_valid = 1'b0;
    query_dst = 5'd0;
    #1;
    chk("pri_qhit_r0", query_hit, 1'b0);
    chk("pri_stall_held", mul_stall, 1'b1);
    tick();
    chk_wb("ord_r1", 32'd10, 5'd1, 1'b0);
    #1;
    chk("ord_stall_rel", mul_stall, 1'b0);
    tick();
    idle();
    chk_wb("ord_r2", 32'd20, 5'd2, 1'b0);
    tick();
    chk_wb("ord_r3", 32'd30, 5'd3, 1'b0);
    tick();
    chk_wb("ord_r4", 32'd40, 5'd4, 1'b0);
    tick();
    chk_wb("ord_r5", 32'd50, 5'd5, 1'b0);
    tick();
    chk("ord_done_en", wb_en, 1'b0);

    // Overflow and r0 destinations
    m5(32'h77, 5'd7, 1'b1);
    tick();
    idle();
    chk("ovf_en", wb_en, 1'b0);
    chk("ovf_exc", mul_exc, 1'b1);
    tick();
    chk("ovf_exc_pulse", mul_exc, 1'b0);
    chk("ovf_no_late_wb", wb_en, 1'b0);
    m5(32'h55, 5'd0, 1'b0);
    tick();
    idle();
    chk("r0_en", wb_en, 1'b0);
    chk("r0_exc", mul_exc, 1'b0);

    // Flush together with an ALU write of zero
    alu(32'h1, 5'd30);
    m5(32'hB, 5'd11, 1'b0);
    tick();
    m5(32'hC, 5'd12, 1'b0);
    tick();
    m5_valid = 1'b0;
    query_dst = 5'd12;
    #1;
    chk("fl_qhit_pre", query_hit, 1'b1);
    alu(32'h0, 5'd3);
    flush = 1'b1;
    tick();
    idle();
    chk_wb("fl_alu", 32'h0, 5'd3, 1'b1);
    chk("fl_qhit_post", query_hit, 1'b0);
    tick();
    chk("fl_no_mul1", wb_en, 1'b0);
    tick();
    chk("fl_no_mul2", wb_en, 1'b0);

    // Hazard query on a buffered dst=9 entry
    alu(32'h2, 5'd31);
    m5(32'h99, 5'd9, 1'b0);
    query_dst = 5'd9;
    #1;
    chk("hz_qhit_m5", query_hit, 1'b1);
    tick();
    m5_valid = 1'b0;
    #1;
    chk("hz_qhit_fifo", query_hit, 1'b1);
    query_dst = 5'd0;
    #1;
    chk("hz_qhit_zero", query_hit, 1'b0);
    query_dst = 5'd9;
    tick();
    alu_valid = 1'b0;
    tick();
    chk_wb("hz_pop", 32'h99, 5'd9, 1'b0);
    chk("hz_qhit_after", query_hit, 1'b0);

    // Reset mid-stream with 3 entries buffered
    for (int k = 1; k <= 3; k++) begin
      alu(32'h40 + 32'(k), 5'd25);
      m5(32'h200 + 32'(k), 5'(k), 1'b0);
      tick();
    end
    idle();
    query_dst = 5'd2;
    #1;
    chk("mr_qhit_pre", query_hit, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_wb_en", wb_en, 1'b0);
    chk("mr_stall", mul_stall, 1'b0);
    chk("mr_qhit", query_hit, 1'b0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_no_wb", wb_en, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
